// File: rtl/riscv_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
package riscv_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FETCH = 2'd1,
      ARB_DATA  = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_FETCH = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_t;

   // A tie goes to whichever channel did not win the previous tie.
   function automatic grant_t tie_winner(input grant_t last_grant);
      return (last_grant == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog for an outstanding memory access: counts cycles while enabled and
// flags the last permitted cycle so the arbiter can abort a hung access.
module mem_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(32'd1);

   logic [CNT_W-1:0] count_r;

   // Cycle counter, restarted on every new grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable) begin
         count_r <= count_r + ONE;
      end
   end

   assign expired = enable & (count_r == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction
// fetch and data access, with stall outputs and a hung-access watchdog.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_re,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);

   arb_state_t        state_r, next_state_s;
   grant_t            last_grant_r, grant_s;
   logic              f_pend_s, d_pend_s, in_access_s, expired_s;
   logic              tie_s, start_s, done_s, abort_s;
   logic              mem_req_r, mem_we_r, if_ack_r, d_ack_r, err_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r, if_rdata_r, d_rdata_r;

   // A request whose ack is showing this cycle is already finished.
   assign f_pend_s    = if_req & ~if_ack_r;
   assign d_pend_s    = (d_re | d_we) & ~d_ack_r;
   assign in_access_s = (state_r != ARB_IDLE);

   mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (start_s),
      .enable  (in_access_s),
      .expired (expired_s)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ARB_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Grant decision and access completion; a ready memory beats the watchdog.
   always_comb begin
      next_state_s = state_r;
      grant_s      = last_grant_r;
      tie_s        = 1'b0;
      start_s      = 1'b0;
      done_s       = 1'b0;
      abort_s      = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            if (f_pend_s && d_pend_s) begin
               tie_s   = 1'b1;
               start_s = 1'b1;
               grant_s = tie_winner(last_grant_r);
            end else if (d_pend_s) begin
               start_s = 1'b1;
               grant_s = GRANT_DATA;
            end else if (f_pend_s) begin
               start_s = 1'b1;
               grant_s = GRANT_FETCH;
            end else begin
               grant_s = last_grant_r;
            end
            if (start_s) begin
               next_state_s = (grant_s == GRANT_DATA) ? ARB_DATA : ARB_FETCH;
            end else begin
               next_state_s = ARB_IDLE;
            end
         end
         ARB_FETCH, ARB_DATA: begin
            if (mem_ready) begin
               done_s       = 1'b1;
               next_state_s = ARB_IDLE;
            end else if (expired_s) begin
               abort_s      = 1'b1;
               next_state_s = ARB_IDLE;
            end else begin
               next_state_s = state_r;
            end
         end
         default: begin
            next_state_s = ARB_IDLE;
         end
      endcase
   end

   // Memory-side latches, acks, read data and the sticky error flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_r <= GRANT_FETCH;
         mem_req_r    <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_wdata_r  <= {DATA_W{1'b0}};
         if_ack_r     <= 1'b0;
         d_ack_r      <= 1'b0;
         if_rdata_r   <= {DATA_W{1'b0}};
         d_rdata_r    <= {DATA_W{1'b0}};
         err_r        <= 1'b0;
      end else begin
         mem_req_r <= (next_state_s != ARB_IDLE);
         if_ack_r  <= (done_s | abort_s) & (state_r == ARB_FETCH);
         d_ack_r   <= (done_s | abort_s) & (state_r == ARB_DATA);
         err_r     <= err_r | abort_s;
         if (start_s) begin
            mem_addr_r <= (grant_s == GRANT_DATA) ? d_addr : if_addr;
            mem_we_r   <= (grant_s == GRANT_DATA) & d_we;
            if (grant_s == GRANT_DATA) begin
               mem_wdata_r <= d_wdata;
            end
            if (tie_s) begin
               last_grant_r <= grant_s;
            end
         end
         if ((state_r == ARB_FETCH) && done_s) begin
            if_rdata_r <= mem_rdata;
         end else if ((state_r == ARB_FETCH) && abort_s) begin
            if_rdata_r <= {DATA_W{1'b0}};
         end
         // Stores complete without disturbing the last load value.
         if ((state_r == ARB_DATA) && done_s && !mem_we_r) begin
            d_rdata_r <= mem_rdata;
         end else if ((state_r == ARB_DATA) && abort_s) begin
            d_rdata_r <= {DATA_W{1'b0}};
         end
      end
   end

   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign if_ack    = if_ack_r;
   assign d_ack     = d_ack_r;
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;
   assign err       = err_r;
   assign stall_if  = f_pend_s;
   assign stall_mem = d_pend_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clock = 1'b0;
   logic          reset, if_req, if_ack, d_re, d_we, d_ack;
   logic          mem_req, mem_we, mem_ready, stall_if, stall_mem, err;
   logic [AW-1:0] if_addr, d_addr, mem_addr;
   logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      if (a == 32'h0000_0040) return 32'h00A0_0093;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference model: one access in service at a time, acks visible one cycle after completion.
   bit            m_busy, m_own_data, m_last_tie_data, m_we, m_ack_f, m_ack_d, m_err;
   int            m_waited;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;

   task automatic model_edge();
      bit fp, dp, own_d, nf, nd;
      nf = 1'b0;
      nd = 1'b0;
      if (reset) begin
         m_busy = 1'b0; m_last_tie_data = 1'b0; m_we = 1'b0; m_err = 1'b0;
         m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0; m_waited = 0;
      end else if (!m_busy) begin
         fp = if_req && !m_ack_f;
         dp = (d_re || d_we) && !m_ack_d;
         if (fp || dp) begin
            own_d = dp && (!fp || !m_last_tie_data);
            if (fp && dp) m_last_tie_data = own_d;
            m_busy = 1'b1; m_own_data = own_d; m_waited = 0;
            m_addr = own_d ? d_addr : if_addr;
            m_we   = own_d && d_we;
            if (own_d) m_wdata = d_wdata;
         end
      end else begin
         m_waited++;
         if (mem_ready) begin
            if (m_own_data) begin nd = 1'b1; if (!m_we) m_d_rdata = mem_rdata; end
            else begin nf = 1'b1; m_if_rdata = mem_rdata; end
            m_busy = 1'b0;
         end else if (m_waited == TO) begin
            if (m_own_data) begin nd = 1'b1; m_d_rdata = '0; end
            else begin nf = 1'b1; m_if_rdata = '0; end
            m_err = 1'b1; m_busy = 1'b0;
         end
      end
      m_ack_f = nf;
      m_ack_d = nd;
   endtask

   // Stimulus agents and memory responder controls.
   bit            rst_v, auto, rereq_all, f_on, d_on, d_rd, d_wr;
   int            rdy_mode, fix_delay, low_left;
   logic [AW-1:0] f_a, d_a;
   logic [DW-1:0] d_wd;

   task automatic new_f();
      f_on = 1'b1;
      f_a  = {1'b0, 29'($urandom), 2'b00};
   endtask

   task automatic new_d();
      int op;
      op   = $urandom_range(0, 2);
      d_on = 1'b1;
      d_rd = (op != 1);
      d_wr = (op != 0);
      d_a  = {1'b1, 29'($urandom), 2'b00};
      d_wd = $urandom;
   endtask

   task automatic drive_inputs();
      if (m_ack_f) begin
         f_on = 1'b0;
         if (auto && (rereq_all || $urandom_range(0, 3) == 0)) new_f();
      end else if (!f_on && auto && $urandom_range(0, 2) == 0) new_f();
      if (m_ack_d) begin
         d_on = 1'b0;
         if (auto && (rereq_all || $urandom_range(0, 3) == 0)) new_d();
      end else if (!d_on && auto && $urandom_range(0, 2) == 0) new_d();
      reset   = rst_v;
      if_req  = f_on;
      if_addr = f_on ? f_a : $urandom;
      d_re    = d_on && d_rd;
      d_we    = d_on && d_wr;
      d_addr  = d_on ? d_a : $urandom;
      d_wdata = d_on ? d_wd : $urandom;
      if (m_busy && m_waited == 0) begin
         case (rdy_mode)
            0: low_left = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 3);
            2: low_left = 1000;
            3: low_left = fix_delay;
            default: low_left = 0;
         endcase
      end
      if (m_busy) begin
         if (low_left > 0) begin mem_ready = 1'b0; low_left--; end
         else mem_ready = 1'b1;
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
      end
      mem_rdata = (m_busy && mem_ready) ? mem_word(mem_addr) : $urandom;
   endtask

   int if_ack_cyc = -100;
   int d_ack_cyc  = -100;
   bit prev_req   = 1'b0;
   bit gq[$];

   task automatic compare_outputs();
      check_val("mem_req",   mem_req,   m_busy);
      check_val("mem_addr",  mem_addr,  m_addr);
      check_val("mem_we",    mem_we,    m_we);
      check_val("mem_wdata", mem_wdata, m_wdata);
      check_val("if_ack",    if_ack,    m_ack_f);
      check_val("d_ack",     d_ack,     m_ack_d);
      check_val("if_rdata",  if_rdata,  m_if_rdata);
      check_val("d_rdata",   d_rdata,   m_d_rdata);
      check_val("stall_if",  stall_if,  if_req && !m_ack_f);
      check_val("stall_mem", stall_mem, (d_re || d_we) && !m_ack_d);
      check_val("err",       err,       m_err);
      if (if_ack === 1'b1) if_ack_cyc = cyc;
      if (d_ack === 1'b1) d_ack_cyc = cyc;
      if (mem_req === 1'b1 && !prev_req) gq.push_back(mem_addr[AW-1]);
      prev_req = (mem_req === 1'b1);
   endtask

   task automatic cycle();
      @(posedge clock);
      model_edge();
      cyc++;
      #1;
      drive_inputs();
      @(negedge clock);
      compare_outputs();
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: run did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      int base;
      logic [DW-1:0] keep;
      reset = 1'b1; if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
      rst_v = 1'b1; auto = 1'b0; rereq_all = 1'b0; rdy_mode = 1; fix_delay = 0; low_left = 0;
      f_on = 1'b0; d_on = 1'b0;
      repeat (3) cycle();

      // Fetch only, memory always ready.
      rst_v = 1'b0; f_on = 1'b1; f_a = 32'h0000_0040;
      cycle(); base = cyc;
      repeat (4) cycle();
      check_val("t1_if_ack_latency", if_ack_cyc - base, 2);
      check_val("t1_if_rdata", if_rdata, 32'h00A0_0093);

      // Simultaneous fetch and load straight after reset: data wins the first tie.
      rst_v = 1'b1; cycle(); rst_v = 1'b0;
      f_on = 1'b1; f_a = 32'h0000_1000;
      d_on = 1'b1; d_rd = 1'b1; d_wr = 1'b0; d_a = 32'h8000_0200;
      cycle(); base = cyc;
      repeat (6) cycle();
      check_val("t2_d_ack_latency", d_ack_cyc - base, 2);
      check_val("t2_if_ack_latency", if_ack_cyc - base, 4);
      check_val("t2_d_rdata", d_rdata, mem_word(32'h8000_0200));

      // Both channels kept busy: grants alternate starting with data.
      rst_v = 1'b1; cycle(); rst_v = 1'b0;
      gq.delete(); auto = 1'b1; rereq_all = 1'b1; new_f(); new_d();
      repeat (21) cycle();
      auto = 1'b0; rereq_all = 1'b0;
      check_val("t3_grant_count_ok", gq.size() >= 8, 1);
      for (int i = 0; i < 8 && i < gq.size(); i++)
         check_val($sformatf("t3_grant%0d_is_data", i), gq[i], (i % 2) == 0);
      repeat (8) cycle();

      // Store with read also raised, memory slow for three cycles.
      keep = m_d_rdata;
      d_on = 1'b1; d_rd = 1'b1; d_wr = 1'b1; d_a = 32'h0000_0100; d_wd = 32'hDEAD_BEEF;
      rdy_mode = 3; fix_delay = 3;
      cycle(); base = cyc;
      repeat (2) cycle();
      check_val("t4_mem_we", mem_we, 1'b1);
      check_val("t4_mem_addr", mem_addr, 32'h0000_0100);
      check_val("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      repeat (4) cycle();
      check_val("t4_d_ack_latency", d_ack_cyc - base, 5);
      check_val("t4_d_rdata_kept", d_rdata, keep);

      // Memory never ready: watchdog aborts the fetch.
      rdy_mode = 2; f_on = 1'b1; f_a = 32'h0000_0080;
      cycle(); base = cyc;
      repeat (19) cycle();
      check_val("t5_if_ack_latency", if_ack_cyc - base, TO + 1);
      check_val("t5_if_rdata_zero", if_rdata, 32'h0);
      check_val("t5_err_set", err, 1'b1);
      repeat (5) cycle();
      check_val("t5_err_sticky", err, 1'b1);

      // Reset during a stalled data access, then a tie after reset.
      d_on = 1'b1; d_rd = 1'b1; d_wr = 1'b0; d_a = 32'h8000_0300;
      repeat (4) cycle();
      rst_v = 1'b1; cycle();
      rst_v = 1'b0; rdy_mode = 1; f_on = 1'b1; f_a = 32'h0000_2000;
      cycle();
      check_val("t6_mem_req_dropped", mem_req, 1'b0);
      check_val("t6_no_d_ack", d_ack, 1'b0);
      check_val("t6_err_cleared", err, 1'b0);
      cycle();
      check_val("t6_tie_to_data", mem_addr, 32'h8000_0300);
      repeat (6) cycle();

      // Randomized traffic with random memory latency and occasional resets.
      auto = 1'b1; rdy_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         rst_v = ($urandom_range(0, 599) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch stage and its memory-access stage. Grants one requester at a time with round-robin tie-breaking. Runs a ready-based handshake toward the memory and returns a one-cycle acknowledge plus registered read data to the granted stage. Drives the stall signals that hold the PC, the IF/ID register and the upstream pipeline while an access is outstanding, and aborts hung accesses with a watchdog.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles to wait for mem_ready before abort (≥2)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid with if_ack
- if_ack  out  1  one-cycle completion pulse
- d_re / d_we  in  1 each  data read / write request, held until d_ack
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completes access this cycle
- stall_if  out  1  hold PC and IF/ID (pc_load low)
- stall_mem  out  1  freeze ID/EX/MEM registers
- err  out  1  sticky timeout flag

## Operation
- States: ARB_IDLE, ARB_FETCH, ARB_DATA.
- IDLE: d_pend = (d_re|d_we) & !d_ack; f_pend = if_req & !if_ack. A request whose ack is high this cycle is ignored.
- Only one pending: grant it.
- Both pending: grant the channel not in last_grant; update last_grant.
- On grant edge: latch addr, wdata (data only) and we = d_we into mem_* registers; clear the watchdog; enter FETCH or DATA.
- d_re and d_we both high: treated as a write.
- FETCH/DATA: mem_req=1 with the latched address.
- When mem_ready=1: capture mem_rdata into if_rdata or d_rdata (writes leave d_rdata unchanged), pulse the matching ack the next cycle, and return to IDLE.
- Watchdog counts cycles in FETCH/DATA. Expiry is reached when the count equals TIMEOUT-1 with mem_ready=0.
- On expiry: the matching ack pulses, rdata is forced to 0, err sets (sticky until reset), and the state returns to IDLE.
- stall_if = f_pend (combinational).
- stall_mem = d_pend (combinational).
- if_rdata and d_rdata hold their value between acks.

## Timing
- Reset: state IDLE, last_grant=FETCH (data wins the first tie), mem_req/mem_we=0, mem_addr/mem_wdata=0, rdata=0, acks=0, err=0, watchdog=0.
- Reset mid-access: abandons the access with no ack; mem_req drops the following cycle.
- Latency with mem_ready tied high:
  - req seen in cycle 0, mem_req in cycle 1, ack and rdata in cycle 2.
  - A new grant can be made in cycle 2 (IDLE), so mem_req returns in cycle 3.
  - Throughput: one access per 2 cycles.
- Each cycle of mem_ready=0 adds one cycle of latency.
- Abort: ack arrives TIMEOUT+1 cycles after the grant edge.
- mem_addr, mem_we and mem_wdata are stable for the whole of mem_req.
- mem_req is low in IDLE.
- Requesters must hold address and data while req is high. Changes after the grant edge are ignored.

## Structure
- Shared package `riscv_pkg`: `arb_state_t` enum (ARB_IDLE, ARB_FETCH, ARB_DATA) and `grant_t` (GRANT_FETCH, GRANT_DATA).
- Sub-module `mem_timeout_counter`:
  - Parameter TIMEOUT; inputs clock, reset, clear, enable; output expired.
  - Counter width $clog2(TIMEOUT).
- Integrates between `instruction_fetch` and `mem`:
  - stall_if gates pc_load and if_id_load.
  - stall_mem gates the EX/MEM-side pipeline registers.

## Test plan
- Fetch only, mem_ready=1, if_addr=0x40, mem_rdata=0x00A00093 -> mem_req in cycle 1 with mem_addr=0x40; if_ack and if_rdata=0x00A00093 in cycle 2; stall_if high for cycles 0–1.
- Simultaneous if_req and d_re right after reset -> data granted first, d_ack in cycle 2; fetch granted in cycle 2, if_ack in cycle 4.
- Both pending continuously for 8 accesses -> grants alternate D,F,D,F…; neither channel starves.
- d_we with d_re, d_addr=0x100, d_wdata=0xDEADBEEF, mem_ready low for 3 cycles -> mem_we=1 and address/data stable throughout; d_ack one cycle after ready; d_rdata unchanged.
- mem_ready stuck low, fetch pending, TIMEOUT=16 -> if_ack 17 cycles after the grant edge with if_rdata=0; err=1 and stays 1 until reset.
- reset asserted while in ARB_DATA with mem_ready low -> next cycle: IDLE, mem_req=0, no d_ack, err=0; after reset a tie is granted to data.
